exp_arbiter: RTL

EXP_ARBITER -- requirements
Module: exp_arbiter

---
 rtl/exp_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin front end that shares one
// exponent engine between two requesters.
module exp_arbiter #(
  parameter logic [31:0] MAX_EXP = 32'd1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_a,
  output logic        req0_ack,
  output logic        req0_done,
  output logic        req0_err,
  output logic [31:0] req0_result,
  input  logic        req1_valid,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_a,
  output logic        req1_ack,
  output logic        req1_done,
  output logic        req1_err,
  output logic [31:0] req1_result,
  output logic        eng_enable,
  output logic [31:0] eng_x,
  output logic [31:0] eng_a,
  input  logic [31:0] eng_p,
  input  logic        eng_ready,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        owner_q, owner_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] res0_q, res0_d;
  logic [31:0] res1_q, res1_d;
  logic        en_q, en_d;
  logic [31:0] ex_q, ex_d;
  logic [31:0] ea_q, ea_d;
  logic        busy_q, busy_d;
  logic [31:0] pres_q, pres_d;
  logic        perr_q, perr_d;

  logic        sel;
  logic [31:0] sel_x;
  logic [31:0] sel_a;
  logic        start;
  logic        over;

  always_comb begin
    sel = 1'b0;
    unique case (1'b1)
      req0_valid & req1_valid:  sel = rr_q;
      ~req0_valid & req1_valid: sel = 1'b1;
      default:                  sel = 1'b0;
    endcase
  end

  assign sel_x = sel ? req1_x : req0_x;
  assign sel_a = sel ? req1_a : req0_a;
  assign over  = sel_a > MAX_EXP;
  assign start = (state_q == IDLE) & eng_ready &
                 (req0_valid | req1_valid);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      en_q    <= 1'b0;
      ex_q    <= '0;
      ea_q    <= '0;
      busy_q  <= 1'b0;
      pres_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      en_q    <= en_d;
      ex_q    <= ex_d;
      ea_q    <= ea_d;
      busy_q  <= busy_d;
      pres_q  <= pres_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = over ? RESP : ISSUE;
      ISSUE:     state_d = WAIT_LOW;
      WAIT_LOW:  if (!eng_ready) state_d = WAIT_HIGH;
      WAIT_HIGH: if (eng_ready) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Result is staged in pres_q and only becomes visible
  // on the owner's ports together with its done pulse.
  always_comb begin
    rr_d    = rr_q;
    owner_d = owner_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = err_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    en_d    = 1'b0;
    ex_d    = ex_q;
    ea_d    = ea_q;
    pres_d  = pres_q;
    perr_d  = perr_q;
    busy_d  = state_d != IDLE;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ack_d[sel] = 1'b1;
          owner_d    = sel;
          ex_d       = sel_x;
          ea_d       = sel_a;
          pres_d     = '0;
          perr_d     = over;
        end
      end
      ISSUE: en_d = 1'b1;
      WAIT_HIGH: begin
        if (eng_ready) begin
          pres_d = eng_p;
          perr_d = 1'b0;
        end
      end
      RESP: begin
        done_d[owner_q] = 1'b1;
        err_d[owner_q]  = perr_q;
        if (owner_q) res1_d = pres_q;
        else         res0_d = pres_q;
        rr_d = ~owner_q;
      end
      default: ;
    endcase
  end

  assign req0_ack    = ack_q[0];
  assign req1_ack    = ack_q[1];
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign req0_err    = err_q[0];
  assign req1_err    = err_q[1];
  assign req0_result = res0_q;
  assign req1_result = res1_q;
  assign eng_enable  = en_q;
  assign eng_x       = ex_q;
  assign eng_a       = ea_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule
